// File: rtl/ascii_decimal_recv_if.sv
// Byte-stream and result bundle between the UART side and the decimal parser.
// Latency: none, wires only.
// Backpressure: none on rx_done; the echo path defers to tx_busy.
interface ascii_decimal_recv_if #(
    parameter int WIDTH = 16
);
    logic             rx_done;
    logic [7:0]       rx_data;
    logic             tx_busy;
    logic             echo_start;
    logic [7:0]       echo_data;
    logic [WIDTH-1:0] value;
    logic             value_valid;
    logic             err;

    modport master (
        output rx_done, rx_data, tx_busy,
        input  echo_start, echo_data, value, value_valid, err
    );

    modport slave (
        input  rx_done, rx_data, tx_busy,
        output echo_start, echo_data, value, value_valid, err
    );
endinterface

// File: rtl/ascii_decimal_recv.sv
// Parses CR/LF-terminated decimal numbers from the UART rx stream and echoes bytes to tx.
// Latency: value_valid/err one cycle after rx_done; echo_start one cycle after capture when tx idle.
// Backpressure: none on rx_done; echo holds one byte and drops arrivals while that byte waits.
module ascii_decimal_recv #(
    parameter int WIDTH   = 16,
    parameter bit ECHO_EN = 1'b1
) (
    input logic                clk,
    input logic                reset,
    ascii_decimal_recv_if.slave bus
);
    localparam int AW = WIDTH + 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIGITS  = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] acc_q, acc_nxt;
    logic [WIDTH-1:0] value_q, value_nxt;
    logic             value_valid_q, value_valid_nxt;
    logic             err_q, err_nxt;

    logic             buf_full_q, echo_start_q;
    logic [7:0]       echo_data_q;
    logic             echo_capture, echo_fire;

    logic             is_digit, is_term, is_cancel;
    logic [3:0]       digit;
    logic [AW-1:0]    acc_ext, acc_mul;
    logic             overflow;

    assign is_digit  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign is_term   = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    assign is_cancel = (bus.rx_data == 8'h1B);
    assign digit     = bus.rx_data[3:0];

    // acc*10 + d in four extra bits cannot wrap, so any high bit set means overflow
    assign acc_ext  = AW'(acc_q);
    assign acc_mul  = (acc_ext << 3) + (acc_ext << 1) + AW'(digit);
    assign overflow = |acc_mul[AW-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            acc_q         <= acc_nxt;
            value_q       <= value_nxt;
            value_valid_q <= value_valid_nxt;
            err_q         <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (bus.rx_done) begin
            case (state_q)
                IDLE: begin
                    if (is_digit)                     state_nxt = DIGITS;
                    else if (!is_term && !is_cancel)  state_nxt = DISCARD;
                end
                DIGITS: begin
                    if (is_digit)                     state_nxt = overflow ? DISCARD : DIGITS;
                    else if (is_term || is_cancel)    state_nxt = IDLE;
                    else                              state_nxt = DISCARD;
                end
                DISCARD: begin
                    if (is_term || is_cancel)         state_nxt = IDLE;
                end
                default:                              state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        acc_nxt         = acc_q;
        value_nxt       = value_q;
        value_valid_nxt = 1'b0;
        err_nxt         = 1'b0;
        if (bus.rx_done) begin
            case (state_q)
                IDLE: begin
                    if (is_digit)                     acc_nxt = WIDTH'(digit);
                    else if (!is_term && !is_cancel)  err_nxt = 1'b1;
                end
                DIGITS: begin
                    if (is_digit) begin
                        if (overflow) begin
                            err_nxt = 1'b1;
                            acc_nxt = '0;
                        end else begin
                            acc_nxt = acc_mul[WIDTH-1:0];
                        end
                    end else if (is_term) begin
                        value_nxt       = acc_q;
                        value_valid_nxt = 1'b1;
                        acc_nxt         = '0;
                    end else if (is_cancel) begin
                        acc_nxt = '0;
                    end else begin
                        err_nxt = 1'b1;
                        acc_nxt = '0;
                    end
                end
                default:                              acc_nxt = '0;
            endcase
        end
    end

    // A byte arriving into an empty buffer while tx is idle is started straight away
    assign echo_capture = ECHO_EN && bus.rx_done && !buf_full_q;
    assign echo_fire    = ECHO_EN && !echo_start_q && !bus.tx_busy && (buf_full_q || echo_capture);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full_q   <= 1'b0;
            echo_start_q <= 1'b0;
            echo_data_q  <= 8'h00;
        end else begin
            buf_full_q   <= (buf_full_q || echo_capture) && !echo_fire;
            echo_start_q <= echo_fire;
            if (echo_capture) echo_data_q <= bus.rx_data;
        end
    end

    assign bus.value       = value_q;
    assign bus.value_valid = value_valid_q;
    assign bus.err         = err_q;
    assign bus.echo_start  = echo_start_q;
    assign bus.echo_data   = echo_data_q;
endmodule

// File: tb/tb_ascii_decimal_recv.sv
// Directed bench for ascii_decimal_recv: table of byte lines plus hand sequences for timing, busy and reset.
module tb_ascii_decimal_recv;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] ESC = 8'h1B;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ascii_decimal_recv_if #(.WIDTH(16)) bus();

    ascii_decimal_recv #(.WIDTH(16), .ECHO_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] bytes;   // first byte in the most significant used position
        int          len;
        int          exp_vv;
        int          exp_err;
        int          exp_val;
    } vec_t;

    vec_t       vt[12];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         vv_cnt = 0;
    int         err_cnt = 0;
    logic       prev_start = 1'b0;
    logic [7:0] echo_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] b, input int len, input int vv, input int er, input int val);
        vec_t v;
        v.bytes   = b;
        v.len     = len;
        v.exp_vv  = vv;
        v.exp_err = er;
        v.exp_val = val;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.value_valid) vv_cnt++;
        if (bus.err) err_cnt++;
        if (bus.value_valid || bus.err)
            check("vv_err_exclusive", longint'(bus.value_valid && bus.err), 0);
        if (bus.echo_start) begin
            echo_q.push_back(bus.echo_data);
            check("echo_start_back_to_back", longint'(prev_start), 0);
        end
        prev_start = bus.echo_start;
    end

    initial begin
        int vv0, e0, q0;

        reset       = 1'b1;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        bus.tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_value",       longint'(bus.value), 0);
        check("reset_value_valid", longint'(bus.value_valid), 0);
        check("reset_err",         longint'(bus.err), 0);
        check("reset_echo_start",  longint'(bus.echo_start), 0);
        check("reset_echo_data",   longint'(bus.echo_data), 0);

        vt[0]  = mk(64'({"123", CR}),           4, 1, 0, 123);
        vt[1]  = mk(64'({"65535", LF}),         6, 1, 0, 65535);
        vt[2]  = mk(64'({"65536", CR}),         6, 0, 1, 65535);
        vt[3]  = mk(64'({"12a4", CR}),          5, 0, 1, 65535);
        vt[4]  = mk(64'({"7", CR}),             2, 1, 0, 7);
        vt[5]  = mk(64'(CR),                    1, 0, 0, 7);
        vt[6]  = mk(64'({ESC, "99", ESC}),      4, 0, 0, 7);
        vt[7]  = mk(64'({"0007", LF}),          5, 1, 0, 7);
        vt[8]  = mk(64'({"abc", CR}),           4, 0, 1, 7);
        vt[9]  = mk(64'({"1", ESC, "2", CR}),   4, 1, 0, 2);
        vt[10] = mk(64'({"0", CR}),             2, 1, 0, 0);
        vt[11] = mk(64'({"x", LF, "42", CR}),   5, 1, 1, 42);

        for (int i = 0; i < 12; i++) begin
            vv0 = vv_cnt;
            e0  = err_cnt;
            q0  = echo_q.size();
            for (int k = vt[i].len - 1; k >= 0; k--)
                send_byte(vt[i].bytes[8*k +: 8]);
            repeat (3) @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_value_valid_count", i), vv_cnt - vv0, vt[i].exp_vv);
            check($sformatf("v%0d_err_count", i), err_cnt - e0, vt[i].exp_err);
            check($sformatf("v%0d_value", i), longint'(bus.value), vt[i].exp_val);
            check($sformatf("v%0d_echo_count", i), echo_q.size() - q0, vt[i].len);
            for (int j = 0; j < vt[i].len; j++)
                if (q0 + j < echo_q.size())
                    check($sformatf("v%0d_echo_byte%0d", i, j), longint'(echo_q[q0 + j]),
                          longint'(vt[i].bytes[8*(vt[i].len - 1 - j) +: 8]));
        end

        // Commit and echo land exactly one cycle after the terminating rx_done
        send_byte("4");
        @(posedge clk);
        #1;
        bus.rx_done = 1'b1;
        bus.rx_data = CR;
        @(negedge clk);
        check("lat_vv_same_cycle", longint'(bus.value_valid), 0);
        @(posedge clk);
        #1 bus.rx_done = 1'b0;
        @(negedge clk);
        check("lat_vv_next_cycle",   longint'(bus.value_valid), 1);
        check("lat_value",           longint'(bus.value), 4);
        check("lat_echo_start",      longint'(bus.echo_start), 1);
        check("lat_echo_data",       longint'(bus.echo_data), 8'h0D);
        repeat (3) @(posedge clk);

        // Busy transmitter: '5' waits in the buffer, '6' is dropped from echo
        q0 = echo_q.size();
        @(posedge clk);
        #1 bus.tx_busy = 1'b1;
        send_byte("5");
        send_byte("6");
        repeat (189) @(posedge clk);
        @(negedge clk);
        check("busy_no_echo",       echo_q.size() - q0, 0);
        check("busy_buffered_data", longint'(bus.echo_data), 8'h35);
        @(posedge clk);
        #1 bus.tx_busy = 1'b0;
        @(negedge clk);
        check("busy_release_early", longint'(bus.echo_start), 0);
        @(negedge clk);
        check("busy_release_start", longint'(bus.echo_start), 1);
        check("busy_release_data",  longint'(bus.echo_data), 8'h35);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("busy_echo_count", echo_q.size() - q0, 1);
        if (echo_q.size() > q0)
            check("busy_echo_byte", longint'(echo_q[q0]), 8'h35);

        // Asynchronous reset in the middle of a number
        send_byte("1");
        send_byte("2");
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_value",       longint'(bus.value), 0);
        check("midrst_value_valid", longint'(bus.value_valid), 0);
        check("midrst_err",         longint'(bus.err), 0);
        check("midrst_echo_start",  longint'(bus.echo_start), 0);
        check("midrst_echo_data",   longint'(bus.echo_data), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        vv0 = vv_cnt;
        e0  = err_cnt;
        send_byte("3");
        send_byte(CR);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("postrst_vv_count",  vv_cnt - vv0, 1);
        check("postrst_err_count", err_cnt - e0, 0);
        check("postrst_value",     longint'(bus.value), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
